// File: rtl/count_mode_sched_if.sv
// Bundle between the game scheduler and its environment: start/requesters on one side, counter control and status on the other.
// Latency: none, wires only.
// Backpressure: none; requesters hold req until granted. COUNT_SCHED_ABORT_EN adds the abort input.
interface count_mode_sched_if #(
    parameter int CW      = 4,
    parameter int GAMES_W = 8
);
    logic               start;
    logic [CW-1:0]      init_value;
    logic [1:0]         req;
    logic [1:0]         req_mode_a;
    logic [1:0]         req_mode_b;
    logic [1:0]         gnt;
    logic [1:0]         control;
    logic               INIT;
    logic [CW-1:0]      initial_value;
    logic               clear;
    logic               GAMEOVER;
    logic [1:0]         WHO;
    logic               busy;
    logic               game_done;
    logic [1:0]         last_who;
    logic [GAMES_W-1:0] games_played;

`ifdef COUNT_SCHED_ABORT_EN
    logic               abort;

    modport master (
        input  start, init_value, req, req_mode_a, req_mode_b, GAMEOVER, WHO, abort,
        output gnt, control, INIT, initial_value, clear, busy, game_done, last_who, games_played
    );
    modport slave (
        output start, init_value, req, req_mode_a, req_mode_b, GAMEOVER, WHO, abort,
        input  gnt, control, INIT, initial_value, clear, busy, game_done, last_who, games_played
    );
`else
    modport master (
        input  start, init_value, req, req_mode_a, req_mode_b, GAMEOVER, WHO,
        output gnt, control, INIT, initial_value, clear, busy, game_done, last_who, games_played
    );
    modport slave (
        output start, init_value, req, req_mode_a, req_mode_b, GAMEOVER, WHO,
        input  gnt, control, INIT, initial_value, clear, busy, game_done, last_who, games_played
    );
`endif
endinterface

// File: rtl/count_mode_sched.sv
// Game sequencer for the up/down counter: clear, load, then round-robin A/B mode arbitration with a fixed dwell; optional abort via COUNT_SCHED_ABORT_EN.
// Latency: all outputs registered; gnt/control one cycle after the arbitration edge; start at edge N -> clear N+1, INIT N+2, first arbitration edge N+3.
// Backpressure: none; a requester holds req until granted, a dropped request is simply never granted.
module count_mode_sched #(
    parameter int COUNT_MAX_VALUE = 15,
    parameter int DWELL_CYCLES    = 8,
    parameter int GAMES_W         = 8
) (
    input  logic               clk,
    input  logic               rst,
    count_mode_sched_if.master bus
);
    localparam int CW = $clog2(COUNT_MAX_VALUE);
    localparam int DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_LOAD  = 3'd2,
        S_RUN   = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t state;
    state_t state_nxt;

    // Registered outputs and their next values
    logic [1:0]         gnt_q,      gnt_nxt;
    logic [1:0]         control_q,  control_nxt;
    logic               init_q,     init_nxt;
    logic [CW-1:0]      ival_q,     ival_nxt;
    logic               clear_q,    clear_nxt;
    logic               busy_q,     busy_nxt;
    logic               done_q,     done_nxt;
    logic [1:0]         who_q,      who_nxt;
    logic [GAMES_W-1:0] games_q,    games_nxt;

    // Internal state: dwell countdown and round-robin pointer (1 = B favoured)
    logic [DW-1:0]      dwell_q,    dwell_nxt;
    logic               ptr_b_q,    ptr_b_nxt;

    logic               win_a;
    logic               win_b;
    logic               abort_hit;

`ifdef COUNT_SCHED_ABORT_EN
    assign abort_hit = bus.abort && (state != S_IDLE);
`else
    assign abort_hit = 1'b0;
`endif

    // Round-robin winner: sole requester wins, a tie goes to the one not granted last
    assign win_a = bus.req[0] && (!bus.req[1] || !ptr_b_q);
    assign win_b = bus.req[1] && (!bus.req[0] ||  ptr_b_q);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: game sequence, abort returns straight to IDLE
    always_comb begin
        state_nxt = state;
        if (abort_hit) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (bus.start) state_nxt = S_CLEAR;
                S_CLEAR: state_nxt = S_LOAD;
                S_LOAD:  state_nxt = S_RUN;
                S_RUN:   if (bus.GAMEOVER) state_nxt = S_DRAIN;
                S_DRAIN: state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Output/datapath next values; status outputs follow the state being entered
    always_comb begin
        gnt_nxt     = 2'b00;
        control_nxt = 2'b00;
        dwell_nxt   = dwell_q;
        ptr_b_nxt   = ptr_b_q;
        ival_nxt    = ival_q;
        who_nxt     = who_q;
        games_nxt   = games_q;
        clear_nxt   = (state_nxt == S_CLEAR) || abort_hit;
        init_nxt    = (state_nxt == S_LOAD);
        busy_nxt    = (state_nxt != S_IDLE);
        done_nxt    = (state_nxt == S_DRAIN);

        if (state == S_IDLE && bus.start) begin
            ival_nxt = bus.init_value;
        end

        if (state == S_LOAD) begin
            dwell_nxt = '0;
        end

        if (state == S_RUN && !abort_hit) begin
            if (bus.GAMEOVER) begin
                // Game end beats arbitration: capture result, no grant
                who_nxt = bus.WHO;
                if (games_q != '1) begin
                    games_nxt = games_q + GAMES_W'(1);
                end
            end else if (dwell_q != '0) begin
                dwell_nxt   = dwell_q - DW'(1);
                control_nxt = control_q;
            end else if (win_a) begin
                gnt_nxt     = 2'b01;
                control_nxt = bus.req_mode_a;
                dwell_nxt   = DWELL_LAST;
                ptr_b_nxt   = 1'b1;
            end else if (win_b) begin
                gnt_nxt     = 2'b10;
                control_nxt = bus.req_mode_b;
                dwell_nxt   = DWELL_LAST;
                ptr_b_nxt   = 1'b0;
            end
        end
    end

    // Output and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_q     <= 2'b00;
            control_q <= 2'b00;
            init_q    <= 1'b0;
            ival_q    <= '0;
            clear_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            who_q     <= 2'b00;
            games_q   <= '0;
            dwell_q   <= '0;
            ptr_b_q   <= 1'b0;
        end else begin
            gnt_q     <= gnt_nxt;
            control_q <= control_nxt;
            init_q    <= init_nxt;
            ival_q    <= ival_nxt;
            clear_q   <= clear_nxt;
            busy_q    <= busy_nxt;
            done_q    <= done_nxt;
            who_q     <= who_nxt;
            games_q   <= games_nxt;
            dwell_q   <= dwell_nxt;
            ptr_b_q   <= ptr_b_nxt;
        end
    end

    assign bus.gnt           = gnt_q;
    assign bus.control       = control_q;
    assign bus.INIT          = init_q;
    assign bus.initial_value = ival_q;
    assign bus.clear         = clear_q;
    assign bus.busy          = busy_q;
    assign bus.game_done     = done_q;
    assign bus.last_who      = who_q;
    assign bus.games_played  = games_q;
endmodule

// File: doc/count_mode_sched.md
Name: count_mode_sched

Overview:
- Controller for the multi-mode up/down counter game block.
- Sequences each game: clear, then load the initial value, then run.
- Shares the counter's 2-bit control input between two requesters (A, B) using round-robin arbitration. Each granted mode is held for a fixed dwell time.
- Watches GAMEOVER/WHO, records the result and counts completed games.

Parameters:
- COUNT_MAX_VALUE, 15, counter terminal value. Counter data width CW = $clog2(COUNT_MAX_VALUE), a localparam (4 at default).
- DWELL_CYCLES, 8, number of cycles a granted mode is held on control. Legal range is 1 or more.
- GAMES_W, 8, width of the games_played counter.

Ports:
- clk  in  1  single clock.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  begin a game. Sampled only in IDLE.
- init_value  in  CW  value to load at game start. Latched when start is accepted.
- req  in  2  mode requests: bit0 = A, bit1 = B. A requester holds its bit until granted.
- req_mode_a  in  2  mode requested by A (00 up by 1, 01 up by 2, 10 down by 1, 11 down by 2).
- req_mode_b  in  2  mode requested by B.
- gnt  out  2  one-hot, one-cycle grant pulse.
- control  out  2  to counter control.
- INIT  out  1  to counter INIT.
- initial_value  out  CW  to counter initial_value.
- clear  out  1  to counter clear.
- GAMEOVER  in  1  from counter.
- WHO  in  2  from counter: 10 = winner, 01 = loser.
- busy  out  1  high in every state except IDLE.
- game_done  out  1  one-cycle pulse when a game ends.
- last_who  out  2  WHO captured at the most recent GAMEOVER.
- games_played  out  GAMES_W  completed-game count, saturating.

Behaviour:
- All outputs are registered.
- Reset (rst high at a clk edge):
  - FSM goes to IDLE.
  - All outputs go to 0.
  - Round-robin pointer favours A.
  - dwell counter is cleared to 0.
  - Reset mid-game abandons the game without incrementing games_played.
- FSM states: IDLE, CLEAR, LOAD, RUN, DRAIN.
- IDLE:
  - control=00, INIT=0, clear=0.
  - start=1 latches init_value and moves to CLEAR.
  - start is ignored in all other states.
- CLEAR: clear=1 for exactly one cycle, then LOAD.
- LOAD: INIT=1 for exactly one cycle with initial_value = the latched value, then RUN. dwell is set to 0.
- RUN arbitration:
  - At each edge where dwell==0 and GAMEOVER==0, arbitrate.
  - If both requesters request, the one not granted last wins.
  - If only one requests, it wins.
  - On a win: control <= the winner's req_mode, gnt <= the winner's one-hot bit (pulse), dwell <= DWELL_CYCLES-1, and the pointer moves so the winner has lowest priority next time.
  - If neither requests: control <= 00, no gnt, dwell stays 0, so arbitration repeats next edge.
- RUN dwell:
  - At each edge where dwell>0, dwell decrements and control holds.
  - A request arriving mid-dwell waits for expiry.
  - A request dropped before its grant produces no grant.
- RUN game end:
  - GAMEOVER=1 at an edge in RUN captures WHO into last_who and moves to DRAIN.
  - games_played increments and saturates at all-ones.
  - GAMEOVER takes priority over arbitration in the same cycle: no gnt is issued.
- DRAIN: control=00, game_done=1 for one cycle, then IDLE.
- GAMEOVER outside RUN is ignored.
- Grant latency: the gnt pulse and the new control value appear in the same cycle, one cycle after the arbitration edge.
- Latency from start to the first counter mode: start at edge N gives clear in cycle N+1, INIT in N+2, first arbitration at edge N+3.

Optional Feature:
- Macro COUNT_SCHED_ABORT_EN.
- When defined:
  - An extra input port abort (1 bit) is added.
  - abort=1 at an edge in CLEAR, LOAD, RUN or DRAIN asserts clear=1 for one cycle, then returns to IDLE.
  - control <= 00, no game_done, games_played and last_who unchanged, pointer unchanged.
  - abort in IDLE is ignored.
  - abort and GAMEOVER in the same cycle: abort wins.
- When not defined: no abort port and no abort logic.

Test Plan:
- rst=1 for 2 cycles, then start with init_value=5 → clear=1 one cycle, INIT=1 with initial_value=5 next cycle, busy=1.
- In RUN with DWELL_CYCLES=8: req=11, req_mode_a=01, req_mode_b=11 held → gnt alternates 01,10,01 at 8-cycle spacing, with control 01,11,01.
- In RUN: req=00 → control=00, no gnt. Then req=10 with mode 10 → gnt=10 one cycle later and control=10.
- GAMEOVER=1 with WHO=10, same cycle as a dwell expiry with req=01 → no gnt, last_who=10, game_done pulse one cycle later, games_played increments by 1, busy=0 after DRAIN.
- GAMES_W=2: run 5 games → games_played sticks at 3.
- With COUNT_SCHED_ABORT_EN defined: abort mid-RUN → one clear pulse, then IDLE, games_played unchanged, no game_done.
